// File: rtl/muller_c_harness_pkg.sv
// muller_harness_pkg: FSM states, LFSR taps, golden C-element and saturating-add helpers
package muller_harness_pkg;
  typedef enum logic [2:0] {IDLE, INIT, APPLY, SETTLE, CHECK, DONE} state_t;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  function automatic logic c_next(input logic [31:0] v, input int n, input logic prev);
    logic [31:0] m;
    m = (n >= 32) ? '1 : (32'h1 << n) - 32'h1;
    return ((v & m) == m) ? 1'b1 : ((v & m) == '0) ? 1'b0 : prev;
  endfunction
  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction
endpackage

// File: rtl/muller_c_harness_sync_debounce.sv
// sync_debounce: 2-FF synchroniser (clk, rst_n, d -> q) plus optional DEB_CYCLES stability filter
module sync_debounce #(
  parameter int DEB_CYCLES = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic s1, s2;
  always_ff @(posedge clk) {s1, s2} <= rst_n ? {d, s1} : 2'b00;
  if (DEB_CYCLES == 0) begin : g_sync
    assign q = s2;
  end else begin : g_deb
    localparam int W = $clog2(DEB_CYCLES + 1);
    logic [W-1:0] cnt;
    logic acc;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt <= '0;
        acc <= 1'b0;
      end else if (s2 == acc) begin
        cnt <= '0;
      end else if (cnt == W'(DEB_CYCLES - 1)) begin
        cnt <= '0;
        acc <= s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
    assign q = acc;
  end
endmodule

// File: rtl/muller_c_harness.sv
// muller_c_harness: drives C-element DUT inputs (dut_in) from switches or LFSR, checks dut_c against a golden model (err_flag/err_count/vec_count/busy/done)
module muller_c_harness
  import muller_harness_pkg::*;
#(
  parameter int          CHANNELS      = 4,
  parameter int          INPUTS        = 2,
  parameter int          DEB_CYCLES    = 330000,
  parameter int          SETTLE_CYCLES = 8,
  parameter int          NUM_VECTORS   = 1024,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                         CLK_33MHZ_FPGA,
  input  logic                         RESET_N,
  input  logic                         mode,
  input  logic [CHANNELS*INPUTS-1:0]   manual_in,
  input  logic [CHANNELS-1:0]          dut_c,
  output logic [CHANNELS*INPUTS-1:0]   dut_in,
  output logic [CHANNELS-1:0]          err_flag,
  output logic [15:0]                  err_count,
  output logic [15:0]                  vec_count,
  output logic                         busy,
  output logic                         done
);
  localparam int N  = CHANNELS * INPUTS;
  localparam int SW = $clog2(SETTLE_CYCLES);
  state_t state, state_n;
  logic [SW-1:0] cnt;
  logic mode_s;
  logic [N-1:0] man_q, vec;
  logic [CHANNELS-1:0] c_s, gold, gold_n, mism;
  logic [15:0] lfsr, lfsr_n;
  sync_debounce #(.DEB_CYCLES(0)) u_mode (.clk(CLK_33MHZ_FPGA), .rst_n(RESET_N), .d(mode), .q(mode_s));
  for (genvar i = 0; i < N; i++) begin : g_sw
    sync_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_sw (.clk(CLK_33MHZ_FPGA), .rst_n(RESET_N), .d(manual_in[i]), .q(man_q[i]));
  end
  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    sync_debounce #(.DEB_CYCLES(0)) u_c (.clk(CLK_33MHZ_FPGA), .rst_n(RESET_N), .d(dut_c[k]), .q(c_s[k]));
    assign gold_n[k] = c_next(32'(vec[k*INPUTS +: INPUTS]), INPUTS, gold[k]);
  end
  assign lfsr_n = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0);
  assign mism   = c_s ^ gold;
  assign busy   = state inside {INIT, APPLY, SETTLE, CHECK};
  assign done   = state == DONE;
  // vectors wider than the LFSR repeat its 16-bit word
  always_comb begin
    vec = '0;
    for (int b = 0; b < N; b++) vec[b] = lfsr[b % 16];
  end
  always_comb begin
    state_n = state;
    if (state != IDLE && !mode_s) state_n = IDLE;
    else
      case (state)
        IDLE:    state_n = mode_s ? INIT : IDLE;
        INIT:    state_n = (cnt == SW'(SETTLE_CYCLES - 1)) ? APPLY : INIT;
        APPLY:   state_n = SETTLE;
        SETTLE:  state_n = (cnt == SW'(SETTLE_CYCLES - 2)) ? CHECK : SETTLE;
        CHECK:   state_n = (vec_count == 16'(NUM_VECTORS - 1)) ? DONE : APPLY;
        default: state_n = state;
      endcase
  end
  always_ff @(posedge CLK_33MHZ_FPGA) begin
    state <= RESET_N ? state_n : IDLE;
    cnt   <= (!RESET_N || state_n != state) ? '0 : cnt + 1'b1;
  end
  always_ff @(posedge CLK_33MHZ_FPGA) begin
    if (!RESET_N) begin
      dut_in    <= '0;
      gold      <= '0;
      lfsr      <= LFSR_SEED;
      err_flag  <= '0;
      err_count <= '0;
      vec_count <= '0;
    end else if (state == IDLE) begin
      if (mode_s) begin
        dut_in    <= '0;
        gold      <= '0;
        lfsr      <= LFSR_SEED;
        err_flag  <= '0;
        err_count <= '0;
        vec_count <= '0;
      end else begin
        dut_in    <= man_q;
        vec_count <= '0;
      end
    end else if (mode_s) begin
      if (state == APPLY) begin
        dut_in <= vec;
        gold   <= gold_n;
        lfsr   <= lfsr_n;
      end
      if (state == CHECK) begin
        err_flag  <= err_flag | mism;
        err_count <= sat_add(err_count, 16'($countones(mism)));
        vec_count <= vec_count + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_muller_c_harness.sv
// tb_muller_c_harness: directed self-checking bench with ideal C-element models and fault injection
module tb_muller_c_harness;
  logic clk = 1'b0;
  logic RESET_N, mode;
  logic [7:0] manual_in, dut_in;
  logic [3:0] dut_c, err_flag, stuck, inv;
  logic [3:0] c_ideal = '0;
  logic [15:0] err_count, vec_count;
  logic busy, done;
  int checks = 0;
  int failures = 0;
  int exp_err;
  logic [15:0] l;
  logic g;
  always #5 clk = ~clk;
  muller_c_harness #(.DEB_CYCLES(4), .NUM_VECTORS(16)) dut (
    .CLK_33MHZ_FPGA(clk), .RESET_N(RESET_N), .mode(mode), .manual_in(manual_in),
    .dut_c(dut_c), .dut_in(dut_in), .err_flag(err_flag), .err_count(err_count),
    .vec_count(vec_count), .busy(busy), .done(done)
  );
  always @(dut_in)
    for (int k = 0; k < 4; k++)
      if (dut_in[2*k +: 2] == 2'b11) c_ideal[k] = 1'b1;
      else if (dut_in[2*k +: 2] == 2'b00) c_ideal[k] = 1'b0;
  assign dut_c = (c_ideal & ~stuck) ^ inv;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    l = 16'hACE1;
    g = 1'b0;
    exp_err = 0;
    for (int v = 0; v < 16; v++) begin
      if (l[5:4] == 2'b11) g = 1'b1;
      else if (l[5:4] == 2'b00) g = 1'b0;
      exp_err += int'(g);
      l = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0);
    end
    RESET_N = 1'b0; mode = 1'b1; manual_in = 8'h00; stuck = 4'h0; inv = 4'h0;
    tick(3);
    chk("rst_dut_in", 32'(dut_in), 0);
    chk("rst_err_flag", 32'(err_flag), 0);
    chk("rst_err_count", 32'(err_count), 0);
    chk("rst_vec_count", 32'(vec_count), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    RESET_N = 1'b1;
    for (int i = 0; i < 3 && !busy; i++) tick(1);
    chk("start_busy", 32'(busy), 1);
    chk("init_dut_in", 32'(dut_in), 0);
    for (int i = 0; i < 50 && dut_in == 8'h00; i++) tick(1);
    chk("vec1", 32'(dut_in), 32'hE1);
    for (int i = 0; i < 400 && !done; i++) tick(1);
    chk("run_done", 32'(done), 1);
    chk("run_busy", 32'(busy), 0);
    chk("run_vec_count", 32'(vec_count), 16);
    chk("run_err_count", 32'(err_count), 0);
    chk("run_err_flag", 32'(err_flag), 0);
    mode = 1'b0;
    tick(4);
    chk("man_done", 32'(done), 0);
    chk("man_busy", 32'(busy), 0);
    chk("man_vec_count", 32'(vec_count), 0);
    chk("man_dut_in_zero", 32'(dut_in), 0);
    manual_in = 8'h03;
    tick(6);
    chk("deb_not_yet", 32'(dut_in[1:0]), 0);
    tick(1);
    chk("deb_accept", 32'(dut_in[1:0]), 3);
    manual_in = 8'h01;
    tick(3);
    manual_in = 8'h03;
    tick(4);
    chk("glitch_a", 32'(dut_in), 3);
    tick(6);
    chk("glitch_b", 32'(dut_in), 3);
    stuck = 4'b0100;
    mode = 1'b1;
    tick(4);
    for (int i = 0; i < 400 && !done; i++) tick(1);
    chk("fault_done", 32'(done), 1);
    chk("fault_err_flag", 32'(err_flag), 32'h4);
    chk("fault_err_count", 32'(err_count), 32'(exp_err));
    chk("fault_vec_count", 32'(vec_count), 16);
    mode = 1'b0;
    tick(4);
    stuck = 4'h0;
    mode = 1'b1;
    for (int i = 0; i < 200 && vec_count != 16'd4; i++) tick(1);
    chk("abort_reach_v4", 32'(vec_count), 4);
    mode = 1'b0;
    tick(2);
    chk("abort_busy_before", 32'(busy), 1);
    tick(1);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    tick(1);
    chk("abort_dut_in", 32'(dut_in), 3);
    mode = 1'b1;
    for (int i = 0; i < 10 && !busy; i++) tick(1);
    chk("restart_busy", 32'(busy), 1);
    chk("restart_vec_count", 32'(vec_count), 0);
    chk("restart_err_count", 32'(err_count), 0);
    chk("restart_err_flag", 32'(err_flag), 0);
    for (int i = 0; i < 50 && dut_in == 8'h00; i++) tick(1);
    chk("restart_vec1", 32'(dut_in), 32'hE1);
    for (int i = 0; i < 50 && vec_count != 16'd1; i++) tick(1);
    chk("restart_vec1_clean", 32'(err_count), 0);
    tick(1);
    force dut.err_count = 16'hFFFE;
    inv = 4'hF;
    tick(1);
    release dut.err_count;
    for (int i = 0; i < 50 && vec_count != 16'd2; i++) tick(1);
    chk("sat_first", 32'(err_count), 32'hFFFF);
    chk("sat_flags", 32'(err_flag), 32'hF);
    for (int i = 0; i < 50 && vec_count != 16'd3; i++) tick(1);
    chk("sat_hold", 32'(err_count), 32'hFFFF);
    chk("sat_vec_count", 32'(vec_count), 3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
